// File: rtl/ten_gig_tx_frame_shaper.sv
// Per-channel TX length shaper in front of the 10G MAC: pads runts with zeros up to the
// minimum length, truncates oversize frames with an abort marker, and counts frames.
module ten_gig_tx_frame_shaper #(
    parameter logic [14:0] P_MIN_LENGTH = 15'd60,
    parameter logic [14:0] P_MAX_LENGTH = 15'd9600,
    parameter int          P_CNT_WIDTH  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_s_axis_tvalid,
    output logic                   o_s_axis_tready,
    input  logic [63:0]            i_s_axis_tdata,
    input  logic [7:0]             i_s_axis_tkeep,
    input  logic                   i_s_axis_tlast,
    input  logic                   i_s_axis_tuser,
    output logic                   o_m_axis_tvalid,
    input  logic                   i_m_axis_tready,
    output logic [63:0]            o_m_axis_tdata,
    output logic [7:0]             o_m_axis_tkeep,
    output logic                   o_m_axis_tlast,
    output logic                   o_m_axis_tuser,
    output logic [P_CNT_WIDTH-1:0] o_frame_cnt,
    output logic [P_CNT_WIDTH-1:0] o_pad_cnt,
    output logic [P_CNT_WIDTH-1:0] o_oversize_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAD,
        DROP
    } state_t;

    localparam logic [P_CNT_WIDTH-1:0] CNT_ONE = {{(P_CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t      state;
    state_t      state_nxt;
    logic        ready_en;
    logic [14:0] byte_cnt;
    logic [14:0] byte_cnt_nxt;
    logic        pad_user;
    logic        pad_user_nxt;
    logic        load_en;
    logic        s_ready;
    logic        s_fire;
    logic [3:0]  beat_bytes;
    logic [14:0] cum;
    logic [14:0] remain;
    logic [63:0] keep_byte_mask;
    logic        emit;
    logic [63:0] e_data;
    logic [7:0]  e_keep;
    logic        e_last;
    logic        e_user;
    logic        inc_frame;
    logic        inc_pad;
    logic        inc_over;

    function automatic logic [3:0] popcount8(input logic [7:0] k);
        logic [3:0] sum;
        sum = 4'd0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + {3'd0, k[i]};
        end
        return sum;
    endfunction

    function automatic logic [7:0] low_mask(input logic [14:0] n);
        if (n >= 15'd8) begin
            return 8'hFF;
        end
        return 8'hFF >> (4'd8 - n[3:0]);
    endfunction

    // ready_en keeps the input side closed while reset is held and for the release cycle
    assign load_en    = !o_m_axis_tvalid || i_m_axis_tready;
    assign beat_bytes = popcount8(i_s_axis_tkeep);
    assign cum        = byte_cnt + {11'd0, beat_bytes};
    assign remain     = P_MIN_LENGTH - byte_cnt;
    assign s_fire     = i_s_axis_tvalid && s_ready;
    assign o_s_axis_tready = s_ready;

    always_comb begin
        s_ready = 1'b0;
        case (state)
            IDLE, DATA: s_ready = ready_en && load_en;
            DROP:       s_ready = ready_en;
            default:    s_ready = 1'b0;
        endcase
    end

    always_comb begin
        keep_byte_mask = '0;
        for (int i = 0; i < 8; i++) begin
            keep_byte_mask[8*i +: 8] = {8{i_s_axis_tkeep[i]}};
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        pad_user_nxt = pad_user;
        emit         = 1'b0;
        e_data       = i_s_axis_tdata;
        e_keep       = i_s_axis_tkeep;
        e_last       = i_s_axis_tlast;
        e_user       = 1'b0;
        inc_frame    = 1'b0;
        inc_pad      = 1'b0;
        inc_over     = 1'b0;
        case (state)
            IDLE, DATA: begin
                if (s_fire) begin
                    emit = 1'b1;
                    if (cum > P_MAX_LENGTH) begin
                        e_last       = 1'b1;
                        e_user       = 1'b1;
                        inc_frame    = 1'b1;
                        inc_over     = 1'b1;
                        byte_cnt_nxt = 15'd0;
                        state_nxt    = i_s_axis_tlast ? IDLE : DROP;
                    end else if (!i_s_axis_tlast) begin
                        byte_cnt_nxt = cum;
                        state_nxt    = DATA;
                    end else if (cum >= P_MIN_LENGTH) begin
                        e_user       = i_s_axis_tuser;
                        inc_frame    = 1'b1;
                        byte_cnt_nxt = 15'd0;
                        state_nxt    = IDLE;
                    end else begin
                        // Runt: the last beat is widened to a full beat of zero fill
                        e_data = i_s_axis_tdata & keep_byte_mask;
                        if ((byte_cnt + 15'd8) < P_MIN_LENGTH) begin
                            e_keep       = 8'hFF;
                            e_last       = 1'b0;
                            pad_user_nxt = i_s_axis_tuser;
                            byte_cnt_nxt = byte_cnt + 15'd8;
                            state_nxt    = PAD;
                        end else begin
                            e_keep       = low_mask(remain);
                            e_last       = 1'b1;
                            e_user       = i_s_axis_tuser;
                            inc_frame    = 1'b1;
                            inc_pad      = 1'b1;
                            byte_cnt_nxt = 15'd0;
                            state_nxt    = IDLE;
                        end
                    end
                end
            end
            PAD: begin
                if (load_en) begin
                    emit   = 1'b1;
                    e_data = 64'd0;
                    if (remain > 15'd8) begin
                        e_keep       = 8'hFF;
                        e_last       = 1'b0;
                        byte_cnt_nxt = byte_cnt + 15'd8;
                    end else begin
                        e_keep       = low_mask(remain);
                        e_last       = 1'b1;
                        e_user       = pad_user;
                        inc_frame    = 1'b1;
                        inc_pad      = 1'b1;
                        byte_cnt_nxt = 15'd0;
                        state_nxt    = IDLE;
                    end
                end
            end
            DROP: begin
                if (s_fire && i_s_axis_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_en        <= 1'b0;
            byte_cnt        <= 15'd0;
            pad_user        <= 1'b0;
            o_m_axis_tvalid <= 1'b0;
            o_m_axis_tdata  <= 64'd0;
            o_m_axis_tkeep  <= 8'd0;
            o_m_axis_tlast  <= 1'b0;
            o_m_axis_tuser  <= 1'b0;
            o_frame_cnt     <= '0;
            o_pad_cnt       <= '0;
            o_oversize_cnt  <= '0;
        end else begin
            ready_en <= 1'b1;
            byte_cnt <= byte_cnt_nxt;
            pad_user <= pad_user_nxt;
            if (load_en) begin
                o_m_axis_tvalid <= emit;
                if (emit) begin
                    o_m_axis_tdata <= e_data;
                    o_m_axis_tkeep <= e_keep;
                    o_m_axis_tlast <= e_last;
                    o_m_axis_tuser <= e_user;
                end
            end
            if (inc_frame) begin
                o_frame_cnt <= o_frame_cnt + CNT_ONE;
            end
            if (inc_pad) begin
                o_pad_cnt <= o_pad_cnt + CNT_ONE;
            end
            if (inc_over) begin
                o_oversize_cnt <= o_oversize_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: doc/ten_gig_tx_frame_shaper.md
Name: ten_gig_tx_frame_shaper

Overview:
Sits directly upstream of the 10G Ethernet channel TX AXI-Stream interface (tx*_axis_*), one instance per channel, in that channel's tx_clk_out domain. It enforces frame-length rules before frames reach the MAC: it zero-pads runts to the minimum length and truncates oversize frames with an error marker. It also keeps per-channel frame statistics.

Parameters:
P_MIN_LENGTH, 15'd60, minimum payload bytes before the MAC appends the 4-byte FCS.
P_MAX_LENGTH, 15'd9600, maximum bytes per frame. Must satisfy P_MAX_LENGTH > P_MIN_LENGTH.
P_CNT_WIDTH, 16, width of the statistics counters.

Ports:
i_clk  in  1  channel tx_clk_out
i_rst_n  in  1  asynchronous, active-low reset
i_s_axis_tvalid  in  1  user frame beat valid
o_s_axis_tready  out  1  user frame beat accepted
i_s_axis_tdata  in  64  frame data, byte0 = [7:0]
i_s_axis_tkeep  in  8  contiguous from LSB; only the tlast beat may be partial
i_s_axis_tlast  in  1  last beat of the frame
i_s_axis_tuser  in  1  user error, sampled on the tlast beat
o_m_axis_tvalid  out  1  to MAC tx_axis_tvalid
i_m_axis_tready  in  1  from MAC tx_axis_tready
o_m_axis_tdata  out  64  to MAC
o_m_axis_tkeep  out  8  to MAC
o_m_axis_tlast  out  1  to MAC
o_m_axis_tuser  out  1  to MAC; 1 on the last beat means abort / bad FCS
o_frame_cnt  out  P_CNT_WIDTH  frames emitted, wrapping
o_pad_cnt  out  P_CNT_WIDTH  frames padded, wrapping
o_oversize_cnt  out  P_CNT_WIDTH  frames truncated, wrapping

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values: all outputs are 0, including o_s_axis_tready. The FSM is in IDLE and the byte counter is 0.
- o_s_axis_tready is 1 from the first cycle after reset release.
- Reset mid-frame: the output beat is discarded immediately. The next accepted input beat after reset starts a new frame.
- Output stage: a single registered stage, so input-to-output latency is 1 cycle when there is no backpressure.
  - The output register loads when it is empty or when i_m_axis_tready=1.
  - o_m_axis_* is held stable while tvalid=1 and tready=0.
- Byte counter: 15 bits, reset per frame. Each beat adds popcount(tkeep). The value includes the current beat ("cum").
- FSM states: IDLE, DATA, PAD, DROP.
  - IDLE/DATA: o_s_axis_tready = !o_m_axis_tvalid || i_m_axis_tready. An accepted beat with tlast=0 moves the FSM to DATA.
  - Normal end: an accepted tlast beat with P_MIN_LENGTH <= cum <= P_MAX_LENGTH is passed unchanged.
    - o_m_axis_tuser = i_s_axis_tuser.
    - FSM goes to IDLE and o_frame_cnt increments.
  - Runt: an accepted tlast beat with cum < P_MIN_LENGTH is emitted as follows.
    - Data bytes where tkeep=0 are forced to 0x00.
    - If the padded total still falls short: tkeep=8'hFF, tlast=0, and the FSM goes to PAD.
    - Otherwise: tkeep = mask up to P_MIN_LENGTH, tlast=1.
    - The i_s_axis_tuser value is carried to the final emitted beat.
  - PAD: o_s_axis_tready=0 and zero-data beats are emitted.
    - Each pad beat has tkeep=8'hFF, except the final beat, whose tkeep = (1<<(P_MIN_LENGTH-8*beats))-1 with tlast=1.
    - When the final beat is loaded: o_pad_cnt and o_frame_cnt increment and the FSM goes to IDLE.
  - Oversize: an accepted beat with cum > P_MAX_LENGTH is emitted with its own tkeep, tlast=1 and tuser=1.
    - o_oversize_cnt and o_frame_cnt increment.
    - FSM goes to DROP if that input beat had tlast=0, otherwise to IDLE.
  - DROP: o_s_axis_tready=1, nothing is emitted, and input is consumed until a tlast beat, then the FSM goes to IDLE.
- A tlast beat that both exceeds P_MAX_LENGTH and is a runt is impossible; the oversize rule takes priority.
- Counters wrap from all-ones to 0.
- An input beat with tkeep=0 is illegal. Behaviour for it is undefined and it is not checked.

Test Plan:
- Basic pass-through: 64-byte frame of 8 full beats, i_m_axis_tready=1 → 8 identical output beats at 1-cycle latency, last tkeep=FF, tuser=0, o_frame_cnt=1.
- Runt padding: 1 beat with tkeep=8'h0F and tlast → 8 output beats.
  - Beat0 data[63:32]=0 with tkeep=FF.
  - Beats 1–6 all zero.
  - Beat7 tkeep=8'h0F, tlast=1.
  - o_s_axis_tready=0 during PAD; o_pad_cnt=1.
- Runt with error: 42-byte frame (5 full beats + tkeep=8'h03) with tuser=1 → 60 bytes out, final tkeep=8'h0F, tuser=1 only on the last beat.
- Oversize: 1210-beat frame → beat 1201 emitted with tlast=1 and tuser=1; the remaining 9 beats are consumed with no output; o_oversize_cnt=1; the next frame passes normally.
- Backpressure: random i_m_axis_tready at 50% during a 100-byte frame → output identical to the input sequence, no beat lost or duplicated, outputs stable while stalled.
- Reset mid-frame: assert i_rst_n=0 during PAD → next edge tvalid=0 and counters=0; after release a 64-byte frame passes unmodified.
